// File: rtl/vga_console_pkg.sv
// vga_console_pkg: shared text-console constants and controller state encoding.
package vga_console_pkg;
  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 10;
  localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_CR = 7'h0D;
  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_DEL = 7'h7F;
  localparam logic [1:0] DEFAULT_COLOR = 2'b00;
  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_COPY, SCROLL_FILL} state_t;
endpackage

// File: rtl/vga_console_cursor_ctrl.sv
// vga_console_cursor_ctrl: terminal write sequencer (chars, CR/LF/BS, scroll, clear) driving the text buffer write port.
module vga_console_cursor_ctrl #(
  parameter int NUM_ROWS = vga_console_pkg::NUM_ROWS,
  parameter int NUM_COLS = vga_console_pkg::NUM_COLS,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_valid,
  input  logic [6:0]        ch_data,
  input  logic [1:0]        ch_color,
  output logic              ch_ready,
  input  logic              clear_req,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col,
  output logic              busy
);
  import vga_console_pkg::*;
  localparam int N_CELLS = NUM_ROWS * NUM_COLS;
  localparam int N_COPY = (NUM_ROWS - 1) * NUM_COLS;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, cur_addr;
  logic [1:0] row, row_n, lat_color, lat_color_n;
  logic [3:0] col, col_n;
  logic [6:0] lat_ch, lat_ch_n;
  logic cp, cp_n, printable, last_col, last_row;
  assign cur_addr = ADDR_W'(row) * ADDR_W'(NUM_COLS) + ADDR_W'(col);
  assign printable = (lat_ch >= CH_SPACE) && (lat_ch != CH_DEL);
  assign last_col = col == 4'(NUM_COLS - 1);
  assign last_row = row == 2'(NUM_ROWS - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      row <= '0;
      col <= '0;
      cp <= 1'b0;
      lat_ch <= '0;
      lat_color <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      row <= row_n;
      col <= col_n;
      cp <= cp_n;
      lat_ch <= lat_ch_n;
      lat_color <= lat_color_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    row_n = row;
    col_n = col;
    cp_n = cp | clear_req;
    lat_ch_n = lat_ch;
    lat_color_n = lat_color;
    case (state)
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(N_CELLS - 1)) begin
          cnt_n = '0;
          row_n = '0;
          col_n = '0;
          state_n = IDLE;
        end
      end
      IDLE:
        // A request arriving this very cycle also beats a pending character.
        if (cp || clear_req) begin
          cp_n = 1'b0;
          state_n = CLEAR;
        end else if (ch_valid) begin
          lat_ch_n = ch_data;
          lat_color_n = ch_color;
          state_n = PUT;
        end
      PUT: begin
        state_n = IDLE;
        if (printable && !last_col) col_n = col + 1'b1;
        else if (printable || lat_ch == CH_LF) begin
          col_n = '0;
          if (last_row) state_n = SCROLL_COPY;
          else row_n = row + 1'b1;
        end else if (lat_ch == CH_CR) col_n = '0;
        else if (lat_ch == CH_BS && col != '0) col_n = col - 1'b1;
      end
      SCROLL_COPY: begin
        // Counter keeps running into the fill phase so it addresses the last row directly.
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(N_COPY - 1)) state_n = SCROLL_FILL;
      end
      SCROLL_FILL: begin
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(N_CELLS - 1)) begin
          cnt_n = '0;
          row_n = 2'(NUM_ROWS - 1);
          col_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = CLEAR;
    endcase
  end
  assign buf_we = rst_n && (state == CLEAR || state == SCROLL_COPY || state == SCROLL_FILL || (state == PUT && printable));
  assign buf_waddr = state == PUT ? cur_addr : cnt;
  assign buf_wdata = state == SCROLL_COPY ? buf_rdata : state == PUT ? {lat_color, lat_ch} : {DEFAULT_COLOR, CH_SPACE};
  assign buf_raddr = cnt + ADDR_W'(NUM_COLS);
  assign ch_ready = rst_n && state == IDLE && !cp;
  assign busy = !rst_n || state != IDLE;
  assign cursor_row = row;
  assign cursor_col = col;
endmodule

// File: tb/tb_vga_console_cursor_ctrl.sv
// tb_vga_console_cursor_ctrl: table-driven and sequence checks of the console cursor controller.
module tb_vga_console_cursor_ctrl;
  logic clk = 0, rst_n = 0, ch_valid = 0, clear_req = 0, preload = 0;
  logic [6:0] ch_data = 0;
  logic [1:0] ch_color = 0;
  logic ch_ready, buf_we, busy;
  logic [4:0] buf_waddr, buf_raddr;
  logic [8:0] buf_wdata, buf_rdata;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic [8:0] mem [32];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  vga_console_cursor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_color(ch_color),
    .ch_ready(ch_ready), .clear_req(clear_req), .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );
  always @(posedge clk)
    if (preload) for (int i = 0; i < 30; i++) mem[i] <= {2'b00, 7'h61 + 7'(i / 10)};
    else if (buf_we) mem[buf_waddr] <= buf_wdata;
  assign buf_rdata = mem[buf_raddr];
  typedef struct {
    logic [6:0] ch;
    logic [1:0] color;
    logic we;
    logic [4:0] addr;
    logic [8:0] data;
    logic [1:0] row;
    logic [3:0] col;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!ch_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", 32'(ch_ready), 1);
  endtask
  task automatic put(input logic [6:0] c, input logic [1:0] col);
    wait_ready();
    ch_valid = 1;
    ch_data = c;
    ch_color = col;
    @(posedge clk);
    @(negedge clk);
    ch_valid = 0;
  endtask
  task automatic sweep(input string n);
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      chk({n, "_we"}, 32'(buf_we), 1);
      chk({n, "_addr"}, 32'(buf_waddr), 32'(i));
      chk({n, "_data"}, 32'(buf_wdata), 32'h020);
      chk({n, "_rdy"}, 32'(ch_ready), 0);
    end
    @(negedge clk);
    chk({n, "_idle_rdy"}, 32'(ch_ready), 1);
    chk({n, "_idle_busy"}, 32'(busy), 0);
    chk({n, "_row"}, 32'(cursor_row), 0);
    chk({n, "_col"}, 32'(cursor_col), 0);
  endtask
  task automatic scroll_body(input string n, input int clr_at, input logic [8:0] last_src);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      clear_req = (k == clr_at);
      chk({n, "_we"}, 32'(buf_we), 1);
      chk({n, "_busy"}, 32'(busy), 1);
      chk({n, "_rdy"}, 32'(ch_ready), 0);
      chk({n, "_addr"}, 32'(buf_waddr), 32'(k));
      if (k < 20) chk({n, "_copy"}, 32'(buf_wdata), k < 10 ? 32'h062 : k < 19 ? 32'h063 : 32'(last_src));
      else chk({n, "_fill"}, 32'(buf_wdata), 32'h020);
    end
    @(negedge clk);
    clear_req = 0;
    chk({n, "_end_busy"}, 32'(busy), 0);
    chk({n, "_end_row"}, 32'(cursor_row), 2);
    chk({n, "_end_col"}, 32'(cursor_col), 0);
  endtask
  initial begin
    tbl.push_back('{7'h41, 2'b10, 1, 0, 9'h141, 0, 1});
    tbl.push_back('{7'h08, 2'b00, 0, 0, 0, 0, 0});
    tbl.push_back('{7'h08, 2'b00, 0, 0, 0, 0, 0});
    tbl.push_back('{7'h01, 2'b11, 0, 0, 0, 0, 0});
    tbl.push_back('{7'h7F, 2'b01, 0, 0, 0, 0, 0});
    tbl.push_back('{7'h0A, 2'b00, 0, 0, 0, 1, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{7'h30 + 7'(i), 2'b01, 1, 5'(10 + i), 9'h0B0 + 9'(i), 1, 4'(i + 1)});
    tbl.push_back('{7'h0D, 2'b00, 0, 0, 0, 1, 0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{7'h50 + 7'(i), 2'b11, 1, 5'(10 + i), 9'h1D0 + 9'(i), i == 9 ? 2'd2 : 2'd1, i == 9 ? 4'd0 : 4'(i + 1)});
    for (int i = 0; i < 9; i++) tbl.push_back('{7'h61, 2'b00, 1, 5'(20 + i), 9'h061, 2, 4'(i + 1)});
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(buf_we), 0);
    chk("rst_rdy", 32'(ch_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    sweep("init_clear");
    foreach (tbl[i]) begin
      put(tbl[i].ch, tbl[i].color);
      chk($sformatf("v%0d_we", i), 32'(buf_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_put_rdy", i), 32'(ch_ready), 0);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(buf_waddr), 32'(tbl[i].addr));
        chk($sformatf("v%0d_data", i), 32'(buf_wdata), 32'(tbl[i].data));
      end
      @(negedge clk);
      chk($sformatf("v%0d_row", i), 32'(cursor_row), 32'(tbl[i].row));
      chk($sformatf("v%0d_col", i), 32'(cursor_col), 32'(tbl[i].col));
      chk($sformatf("v%0d_rdy", i), 32'(ch_ready), 1);
    end
    preload = 1;
    @(negedge clk);
    preload = 0;
    put(7'h5A, 2'b00);
    chk("z_we", 32'(buf_we), 1);
    chk("z_addr", 32'(buf_waddr), 29);
    chk("z_data", 32'(buf_wdata), 32'h05A);
    ch_valid = 1;
    ch_data = 7'h51;
    scroll_body("scrl", -1, 9'h05A);
    chk("scrl_rdy", 32'(ch_ready), 1);
    ch_valid = 0;
    chk("scrl_mem0", 32'(mem[0]), 32'h062);
    chk("scrl_mem19", 32'(mem[19]), 32'h05A);
    chk("scrl_mem29", 32'(mem[29]), 32'h020);
    preload = 1;
    @(negedge clk);
    preload = 0;
    put(7'h0A, 2'b00);
    chk("lf_we", 32'(buf_we), 0);
    scroll_body("scrl_clr", 4, 9'h063);
    chk("pend_rdy", 32'(ch_ready), 0);
    @(negedge clk);
    sweep("req_clear");
    put(7'h0A, 2'b00);
    put(7'h0A, 2'b00);
    put(7'h0A, 2'b00);
    repeat (3) @(negedge clk);
    chk("mid_we", 32'(buf_we), 1);
    rst_n = 0;
    #1 chk("mid_rst_we", 32'(buf_we), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_we2", 32'(buf_we), 0);
      chk("mid_rst_rdy", 32'(ch_ready), 0);
      chk("mid_rst_busy", 32'(busy), 1);
    end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    sweep("rst_clear");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
